// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
//
// fetch_entry_t is the prefetch-queue entry. Its fields are sized for the widest
// supported XLEN (FetchXlenMax). Narrower builds zero-extend on write and truncate
// on read, and synthesis removes the constant upper bits.
package fetch_pkg;

  localparam int unsigned FetchXlenMax = 64;

  // Default first fetch address after reset.
  localparam logic [31:0] FetchResetPc = 32'h0000_0000;

  typedef struct packed {
    logic [FetchXlenMax-1:0] instr;
    logic [FetchXlenMax-1:0] pc;
    logic                    misaligned;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Prefetch queue: a synchronous FIFO of fetch_entry_t with a flush input.
//
// Ports:
//   clk_i, rst_ni  clock and asynchronous active-low reset
//   flush_i        empties the queue. A push in the same cycle is kept and becomes
//                  the only entry.
//   push_i         push_data_i is written when there is room (or when a pop or flush
//                  frees a slot in the same cycle)
//   pop_i          removes the head entry; ignored when the queue is empty
//   head_o         oldest entry. Only meaningful when empty_o is low.
//   empty_o        queue holds no entries
//   count_o        number of entries held (0..Depth)
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  fetch_entry_t               push_data_i,
  input  logic                       pop_i,
  output fetch_entry_t               head_o,
  output logic                       empty_o,
  output logic [$clog2(Depth):0]     count_o
);

  localparam int unsigned AddrW = $clog2(Depth);
  localparam int unsigned CntW  = AddrW + 1;

  fetch_entry_t   mem_q [Depth];
  logic [AddrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AddrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;
  logic [AddrW-1:0] waddr;

  always_comb begin
    do_pop  = pop_i && (count_q != '0) && !flush_i;
    do_push = push_i && ((count_q != CntW'(Depth)) || do_pop || flush_i);
    waddr   = wr_ptr_q;
    if (flush_i) begin
      // Flush restarts both pointers at slot 0. A simultaneous push lands there.
      waddr    = '0;
      rd_ptr_d = '0;
      wr_ptr_d = AddrW'(do_push);
      count_d  = CntW'(do_push);
    end else begin
      // Depth is a power of two, so the pointers wrap naturally.
      rd_ptr_d = rd_ptr_q + AddrW'(do_pop);
      wr_ptr_d = wr_ptr_q + AddrW'(do_push);
      count_d  = count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= '0;
      end
    end else if (do_push) begin
      mem_q[waddr] <= push_data_i;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues sequential fetch requests, tags the in-order
// responses with their PC, and buffers them in a prefetch queue for decode.
//
// Parameters: XLEN (address/instruction width), RESET_PC (first fetch address),
//             QDEPTH (queue entries, power of two >= 2),
//             MAX_OUT (maximum outstanding requests, 1..QDEPTH).
// Ports:
//   clk, reset                      clock and asynchronous active-low reset
//   redirect_valid, redirect_pc     branch/jump/trap redirect strobe and target
//   memreq_valid/ready/addr         fetch request handshake
//   memresp_valid/data              in-order response strobe and instruction
//   out_valid/ready                 decode handshake (out_ready low stalls)
//   out_instr/pc/next_pc            head entry instruction, its PC, and PC+4
//   out_misaligned                  head entry is a misaligned-target fault
//
// Build option FETCH_MISALIGN_TRAP_EN: a redirect whose target has nonzero low
// bits pushes one fault entry and stops fetching until the next redirect.
// Without it, the low target bits are cleared and out_misaligned is 0.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(FetchResetPc),
  parameter int unsigned     QDEPTH   = 4,
  parameter int unsigned     MAX_OUT  = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            memreq_valid,
  input  logic            memreq_ready,
  output logic [XLEN-1:0] memreq_addr,
  input  logic            memresp_valid,
  input  logic [XLEN-1:0] memresp_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_next_pc,
  output logic            out_misaligned
);

  localparam int unsigned CntW = $clog2(QDEPTH) + 1;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  // outstanding_q includes requests whose responses will be dropped.
  logic [CntW-1:0] outstanding_q, outstanding_d;
  logic [CntW-1:0] drop_cnt_q, drop_cnt_d;
  logic            trap_hold_q, trap_hold_d;

  logic            req_fire, resp_in, resp_drop, resp_push;
  logic [CntW:0]   credit_sum;
  logic [XLEN-1:0] redir_pc;
  logic            redir_misaligned;

  fetch_entry_t    push_entry, head;
  logic            q_push, q_pop, q_empty;
  logic [CntW-1:0] q_count;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign redir_pc         = redirect_pc;
  assign redir_misaligned = (redirect_pc[1:0] != 2'b00);
`else
  assign redir_pc         = {redirect_pc[XLEN-1:2], 2'b00};
  assign redir_misaligned = 1'b0;
  logic unused_redir_lsb;
  assign unused_redir_lsb = ^redirect_pc[1:0];
`endif

  // Credit rule: every in-flight request may still land in the queue, so the
  // in-flight and queued entries together must never exceed the queue depth.
  assign credit_sum   = {1'b0, outstanding_q} + {1'b0, q_count};
  assign memreq_valid = reset && !redirect_valid && !trap_hold_q &&
                        (outstanding_q < CntW'(MAX_OUT)) &&
                        (credit_sum < (CntW + 1)'(QDEPTH));
  assign memreq_addr  = fetch_pc_q;

  always_comb begin
    req_fire  = memreq_valid && memreq_ready;
    // Ignore a response when nothing is in flight, so the counters cannot underflow.
    resp_in   = memresp_valid && (outstanding_q != '0);
    resp_drop = resp_in && (drop_cnt_q != '0);
    resp_push = resp_in && (drop_cnt_q == '0) && !redirect_valid;

    outstanding_d = outstanding_q + CntW'(req_fire) - CntW'(resp_in);
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    drop_cnt_d    = drop_cnt_q;
    trap_hold_d   = trap_hold_q;

    if (redirect_valid) begin
      fetch_pc_d  = redir_pc;
      resp_pc_d   = redir_pc;
      // Every request still in flight after this edge belongs to the old path.
      drop_cnt_d  = outstanding_d;
      trap_hold_d = redir_misaligned;
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + XLEN'(4);
      end
      if (resp_push) begin
        resp_pc_d = resp_pc_q + XLEN'(4);
      end
      if (resp_drop) begin
        drop_cnt_d = drop_cnt_q - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      trap_hold_q   <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      trap_hold_q   <= trap_hold_d;
    end
  end

  // A redirect either pushes the misaligned-fault entry or nothing. Otherwise a
  // live response is pushed with its PC tag.
  always_comb begin
    push_entry = '0;
    if (redirect_valid) begin
      push_entry.pc         = FetchXlenMax'(redir_pc);
      push_entry.misaligned = 1'b1;
    end else begin
      push_entry.instr = FetchXlenMax'(memresp_data);
      push_entry.pc    = FetchXlenMax'(resp_pc_q);
    end
  end

  assign q_push = resp_push || (redirect_valid && redir_misaligned);
  assign q_pop  = out_valid && out_ready;

  fetch_queue #(
    .Depth (QDEPTH)
  ) u_queue (
    .clk_i       (clk),
    .rst_ni      (reset),
    .flush_i     (redirect_valid),
    .push_i      (q_push),
    .push_data_i (push_entry),
    .pop_i       (q_pop),
    .head_o      (head),
    .empty_o     (q_empty),
    .count_o     (q_count)
  );

  // Outputs read as zero while the queue is empty.
  assign out_valid   = !q_empty;
  assign out_instr   = out_valid ? head.instr[XLEN-1:0] : '0;
  assign out_pc      = out_valid ? head.pc[XLEN-1:0] : '0;
  assign out_next_pc = out_valid ? (head.pc[XLEN-1:0] + XLEN'(4)) : '0;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign out_misaligned = out_valid && head.misaligned;
`else
  assign out_misaligned = 1'b0;
`endif

  // The entry fields are wider than XLEN. This sink collects the bits that are
  // not read.
  logic unused_head;
  assign unused_head = ^head;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, address/instruction width.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 SHALL have parameter QDEPTH, default 4, prefetch queue entries; power of two, >=2.
REQ-004 SHALL have parameter MAX_OUT, default 2, maximum outstanding memory requests; 1..QDEPTH.
REQ-005 SHALL have port clk  in  1  sole clock, rising edge.
REQ-006 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port redirect_valid  in  1  branch/jump/trap redirect strobe.
REQ-008 SHALL have port redirect_pc  in  XLEN  redirect target.
REQ-009 SHALL have port memreq_valid  out  1  request valid.
REQ-010 SHALL have port memreq_ready  in  1  memory accepts request.
REQ-011 SHALL have port memreq_addr  out  XLEN  request address.
REQ-012 SHALL have port memresp_valid  in  1  in-order response strobe.
REQ-013 SHALL have port memresp_data  in  XLEN  returned instruction.
REQ-014 SHALL have port out_valid  out  1  decode entry valid.
REQ-015 SHALL have port out_ready  in  1  decode accepts entry (low = stall).
REQ-016 SHALL have ports out_instr, out_pc, out_next_pc  out  XLEN each  head entry instruction, its PC, PC+4.
REQ-017 SHALL have port out_misaligned  out  1  head entry is a misaligned-target fault.

Function
REQ-018 Request handshake: transfer when memreq_valid && memreq_ready; memreq_addr and memreq_valid SHALL stay stable while valid && !ready, except on redirect.
REQ-019 memreq_valid SHALL be 1 only if outstanding < MAX_OUT and outstanding + queue_count < QDEPTH (credit rule; queue never overflows).
REQ-020 Each accepted request SHALL advance fetch_pc by 4, modulo 2^XLEN (wrap 32'hFFFF_FFFC -> 0).
REQ-021 Responses SHALL be in order; resp_pc register tags each, +4 per accepted response.
REQ-022 Accepted response SHALL be pushed to the queue and appear at out_* the next cycle (1-cycle latency); if queue was empty it becomes head.
REQ-023 Pop on out_valid && out_ready; push and pop in the same cycle SHALL both occur, count unchanged.
REQ-024 out_valid SHALL equal queue non-empty; out_* held stable while out_valid && !out_ready.
REQ-025 Redirect (highest priority): fetch_pc and resp_pc <= redirect_pc; queue flushed; out_valid = 0 next cycle; memreq_valid forced 0 in the redirect cycle.
REQ-026 Redirect SHALL load drop_cnt = outstanding at redirect, including any request accepted and excluding any response received that same cycle; the next drop_cnt responses SHALL be discarded without push.
REQ-027 New requests after redirect MAY issue while drop_cnt > 0; credit rule counts dropped-pending requests as outstanding.
REQ-028 Back-to-back redirects SHALL accumulate correctly; last redirect wins.

Reset
REQ-029 reset low SHALL immediately set fetch_pc = resp_pc = RESET_PC, outstanding = drop_cnt = 0, queue empty, memreq_valid = 0, out_valid = 0, out_misaligned = 0, out_instr/out_pc/out_next_pc = 0.
REQ-030 First request SHALL be issued in the first cycle after reset release, address RESET_PC.
REQ-031 Reset mid-transfer SHALL discard all state; responses to pre-reset requests are the memory's responsibility to suppress.

Configuration
REQ-032 Macro FETCH_MISALIGN_TRAP_EN defined: redirect_pc[1:0] != 0 SHALL push one entry (out_misaligned = 1, out_pc = redirect_pc, out_instr = 0) and hold memreq_valid = 0 until the next redirect.
REQ-033 Macro undefined: redirect_pc[1:0] SHALL be forced to 0 and out_misaligned tied 0.

Structure
REQ-034 Package fetch_pkg SHALL hold the queue-entry typedef (instr, pc, misaligned) and default RESET_PC constant.
REQ-035 Queue SHALL be sub-module fetch_queue (synchronous FIFO, flush input, count output).

Verification
REQ-036 Reset release, memory always ready, 1-cycle response, out_ready = 1 -> entries PC 0x0, 0x4, 0x8 on consecutive cycles, out_next_pc = PC+4.
REQ-037 out_ready = 0 with QDEPTH = 4 -> queue fills with 4 entries, memreq_valid deasserts, head PC 0x0 held stable; release -> drains in order.
REQ-038 Two outstanding requests (0x8, 0xC), redirect to 0x100 before responses -> both responses dropped, next out_pc = 0x100.
REQ-039 memreq_ready low 3 cycles -> memreq_addr constant; no entry lost or duplicated.
REQ-040 Redirect to 0xFFFF_FFFC -> out_pc sequence 0xFFFF_FFFC, 0x0000_0000.
REQ-041 With FETCH_MISALIGN_TRAP_EN, redirect to 0x102 -> single entry out_misaligned = 1, out_pc = 0x102, no requests until next redirect.
